// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: requester ownership encoding and
// the func3 memory-control codes that the core control unit also decodes.
package dm_arbiter_pkg;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_EXT = 1'b1
   } owner_e;

   // Loads and stores share the low func3 codes; the we bit tells them apart.
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   function automatic owner_e other_owner(input owner_e o);
      return (o == OWN_CPU) ? OWN_EXT : OWN_CPU;
   endfunction

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-input round-robin grant between the core and the external port, with a lock
// override that forces the external port to win contention while a burst is held.
module dm_arbiter_rr_arb2
   import dm_arbiter_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic req_cpu_i,
   input  logic req_ext_i,
   input  logic lock_hold_i,
   output logic gnt_cpu_o,
   output logic gnt_ext_o
);

   owner_e last_winner_q;
   owner_e last_winner_d;
   owner_e rr_pick;

   assign rr_pick = other_owner(last_winner_q);

   always_comb begin
      gnt_cpu_o     = 1'b0;
      gnt_ext_o     = 1'b0;
      last_winner_d = last_winner_q;
      if (req_cpu_i && req_ext_i) begin
         if (lock_hold_i || (rr_pick == OWN_EXT)) begin
            gnt_ext_o = 1'b1;
         end else begin
            gnt_cpu_o = 1'b1;
         end
      end else begin
         gnt_cpu_o = req_cpu_i;
         gnt_ext_o = req_ext_i;
      end
      // Idle cycles leave the round-robin pointer untouched.
      if (gnt_cpu_o) begin
         last_winner_d = OWN_CPU;
      end else if (gnt_ext_o) begin
         last_winner_d = OWN_EXT;
      end
   end

   // Resetting to EXT lets the core win the first contention.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_winner_q <= OWN_EXT;
      end else begin
         last_winner_q <= last_winner_d;
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the core load/store path (zero latency)
// and an external loader/debug port (registered read data, bounded burst lock).
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_LOCK = 8
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [2:0]        cpu_func3_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic              cpu_stall_o,
   output logic [DATA_W-1:0] cpu_rdata_o,
   input  logic              ext_req_i,
   input  logic              ext_we_i,
   input  logic [2:0]        ext_func3_i,
   input  logic [ADDR_W-1:0] ext_addr_i,
   input  logic [DATA_W-1:0] ext_wdata_i,
   input  logic              ext_lock_i,
   output logic              ext_gnt_o,
   output logic [DATA_W-1:0] ext_rdata_o,
   output logic              ext_rvalid_o,
   output logic [ADDR_W-1:0] dm_addr_o,
   output logic [DATA_W-1:0] dm_wdata_o,
   output logic [2:0]        dm_ctrl_o,
   output logic              dm_wenable_o,
   input  logic [DATA_W-1:0] dm_rdata_i
);

   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

   logic              lock_active_q, lock_active_d;
   logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
   logic              ext_rvalid_q, ext_rvalid_d;

   logic gnt_cpu;
   logic gnt_ext;
   logic lock_hold;

   // Once MAX_LOCK locked grants have been served the lock stops overriding round-robin.
   assign lock_hold = lock_active_q && (lock_cnt_q < CNT_MAX);

   dm_arbiter_rr_arb2 u_rr_arb2 (
      .clk_i       (clk_i),
      .rst_i       (reset_i),
      .req_cpu_i   (cpu_req_i),
      .req_ext_i   (ext_req_i),
      .lock_hold_i (lock_hold),
      .gnt_cpu_o   (gnt_cpu),
      .gnt_ext_o   (gnt_ext)
   );

   always_comb begin
      dm_addr_o    = '0;
      dm_wdata_o   = '0;
      dm_ctrl_o    = '0;
      dm_wenable_o = 1'b0;
      if (gnt_cpu) begin
         dm_addr_o    = cpu_addr_i;
         dm_wdata_o   = cpu_wdata_i;
         dm_ctrl_o    = cpu_func3_i;
         dm_wenable_o = cpu_we_i;
      end else if (gnt_ext) begin
         dm_addr_o    = ext_addr_i;
         dm_wdata_o   = ext_wdata_i;
         dm_ctrl_o    = ext_func3_i;
         dm_wenable_o = ext_we_i;
      end
   end

   assign cpu_stall_o  = cpu_req_i & ~gnt_cpu;
   assign cpu_rdata_o  = gnt_cpu ? dm_rdata_i : '0;
   assign ext_gnt_o    = gnt_ext;
   assign ext_rdata_o  = ext_rdata_q;
   assign ext_rvalid_o = ext_rvalid_q;

   always_comb begin
      lock_active_d = gnt_ext & ext_lock_i;
      lock_cnt_d    = lock_cnt_q;
      if (gnt_cpu || !ext_req_i) begin
         lock_cnt_d = '0;
      end else if (gnt_ext && lock_active_q && (lock_cnt_q < CNT_MAX)) begin
         lock_cnt_d = lock_cnt_q + CNT_W'(1);
      end
      ext_rvalid_d = gnt_ext & ~ext_we_i;
      ext_rdata_d  = ext_rvalid_d ? dm_rdata_i : ext_rdata_q;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         lock_active_q <= 1'b0;
         lock_cnt_q    <= '0;
         ext_rdata_q   <= '0;
         ext_rvalid_q  <= 1'b0;
      end else begin
         lock_active_q <= lock_active_d;
         lock_cnt_q    <= lock_cnt_d;
         ext_rdata_q   <= ext_rdata_d;
         ext_rvalid_q  <= ext_rvalid_d;
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: a behavioural arbiter/memory model predicts every
// cycle's outputs into a queue that a separate monitor drains and compares.
module tb_dm_arbiter;
   import dm_arbiter_pkg::*;

   localparam int MAX_LOCK = 8;

   typedef struct packed {
      logic        rst;
      logic        creq;
      logic        cwe;
      logic [2:0]  cf3;
      logic [31:0] caddr;
      logic [31:0] cwd;
      logic        ereq;
      logic        ewe;
      logic [2:0]  ef3;
      logic [31:0] eaddr;
      logic [31:0] ewd;
      logic        elock;
   } stim_t;

   typedef struct packed {
      logic        stall;
      logic [31:0] cpu_rdata;
      logic        ext_gnt;
      logic [31:0] dm_addr;
      logic [31:0] dm_wdata;
      logic [2:0]  dm_ctrl;
      logic        dm_wen;
      logic        rvalid;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 0, cpu_we = 0, ext_req = 0, ext_we = 0, ext_lock = 0;
   logic [2:0]  cpu_func3 = 0, ext_func3 = 0;
   logic [31:0] cpu_addr = 0, cpu_wdata = 0, ext_addr = 0, ext_wdata = 0;
   logic        cpu_stall, ext_gnt, ext_rvalid, dm_wenable;
   logic [31:0] cpu_rdata, ext_rdata, dm_addr, dm_wdata, dm_rdata;
   logic [2:0]  dm_ctrl;

   always #5 clk = ~clk;

   dm_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(MAX_LOCK)) dut (
      .clk_i(clk), .reset_i(reset),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_func3_i(cpu_func3),
      .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
      .cpu_stall_o(cpu_stall), .cpu_rdata_o(cpu_rdata),
      .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_func3_i(ext_func3),
      .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata), .ext_lock_i(ext_lock),
      .ext_gnt_o(ext_gnt), .ext_rdata_o(ext_rdata), .ext_rvalid_o(ext_rvalid),
      .dm_addr_o(dm_addr), .dm_wdata_o(dm_wdata), .dm_ctrl_o(dm_ctrl),
      .dm_wenable_o(dm_wenable), .dm_rdata_i(dm_rdata)
   );

   // Environment memory: combinational read, write at the rising edge.
   logic [31:0] mem [0:255];
   assign dm_rdata = mem[dm_addr[9:2]];
   always @(posedge clk) if (dm_wenable) mem[dm_addr[9:2]] <= dm_wdata;

   // Reference model state.
   logic [31:0] ref_mem [0:255];
   bit          m_last_ext;
   bit          m_locked;
   int          m_nlocked;
   bit          m_rv;
   logic [31:0] m_rdata;
   bit          prev_stall;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   cyc      = 0;

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h0101_0101) ^ 32'hA5C3_0F96;
   endfunction

   task automatic model_step(input stim_t s);
      exp_t e;
      bit   cw, ew;
      if (s.rst) begin
         m_last_ext = 1; m_locked = 0; m_nlocked = 0; m_rv = 0; m_rdata = '0;
      end
      e = '0;
      e.rvalid = m_rv;
      e.rdata  = m_rdata;
      cw = 0; ew = 0;
      if (s.creq && s.ereq) begin
         if (m_locked && m_nlocked < MAX_LOCK) ew = 1;
         else if (m_last_ext)                  cw = 1;
         else                                  ew = 1;
      end else begin
         cw = s.creq; ew = s.ereq;
      end
      e.stall   = s.creq && !cw;
      e.ext_gnt = ew;
      if (cw) begin
         e.dm_addr = s.caddr; e.dm_wdata = s.cwd; e.dm_ctrl = s.cf3; e.dm_wen = s.cwe;
         e.cpu_rdata = ref_mem[s.caddr[9:2]];
      end else if (ew) begin
         e.dm_addr = s.eaddr; e.dm_wdata = s.ewd; e.dm_ctrl = s.ef3; e.dm_wen = s.ewe;
      end
      exp_q.push_back(e);
      prev_stall = e.stall;
      if (!s.rst) begin
         if (cw) m_last_ext = 0;
         else if (ew) m_last_ext = 1;
         if (cw || !s.ereq) m_nlocked = 0;
         else if (ew && m_locked && m_nlocked < MAX_LOCK) m_nlocked++;
         m_locked = ew && s.elock;
         m_rv     = ew && !s.ewe;
         if (m_rv) m_rdata = ref_mem[s.eaddr[9:2]];
      end
      if (e.dm_wen) ref_mem[e.dm_addr[9:2]] = e.dm_wdata;
   endtask

   task automatic drive(input stim_t s);
      @(negedge clk);
      reset = s.rst;
      cpu_req = s.creq; cpu_we = s.cwe; cpu_func3 = s.cf3; cpu_addr = s.caddr; cpu_wdata = s.cwd;
      ext_req = s.ereq; ext_we = s.ewe; ext_func3 = s.ef3; ext_addr = s.eaddr; ext_wdata = s.ewd;
      ext_lock = s.elock;
      #1;
      model_step(s);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, expv);
      end
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle after inputs settle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("cpu_stall",  32'(cpu_stall),  32'(e.stall));
            chk("cpu_rdata",  cpu_rdata,       e.cpu_rdata);
            chk("ext_gnt",    32'(ext_gnt),    32'(e.ext_gnt));
            chk("dm_addr",    dm_addr,         e.dm_addr);
            chk("dm_wdata",   dm_wdata,        e.dm_wdata);
            chk("dm_ctrl",    32'(dm_ctrl),    32'(e.dm_ctrl));
            chk("dm_wenable", 32'(dm_wenable), 32'(e.dm_wen));
            chk("ext_rvalid", 32'(ext_rvalid), 32'(e.rvalid));
            chk("ext_rdata",  ext_rdata,       e.rdata);
         end
      end
   end

   function automatic logic [2:0] rand_f3(input bit we);
      logic [2:0] ld [5];
      logic [2:0] st [3];
      ld = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      st = '{F3_SB, F3_SH, F3_SW};
      return we ? st[$urandom_range(0, 2)] : ld[$urandom_range(0, 4)];
   endfunction

   initial begin
      stim_t s;
      for (int i = 0; i < 256; i++) begin
         mem[i] = init_word(i); ref_mem[i] = init_word(i);
      end
      mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
      m_last_ext = 1; m_locked = 0; m_nlocked = 0; m_rv = 0; m_rdata = '0; prev_stall = 0;

      // Reset with no requests.
      s = '0; s.rst = 1;
      drive(s); drive(s);
      // Contention right after reset: CPU first, then alternating.
      s = '0; s.creq = 1; s.caddr = 32'h40; s.cf3 = F3_LW;
      s.ereq = 1; s.eaddr = 32'h44; s.ef3 = F3_LW;
      repeat (6) drive(s);
      s = '0; drive(s);
      // CPU-only load of 0x10.
      s = '0; s.creq = 1; s.caddr = 32'h10; s.cf3 = F3_LW; drive(s);
      // EXT store then load of 0x20, then a cycle for the rvalid pulse.
      s = '0; s.ereq = 1; s.ewe = 1; s.ef3 = F3_SW; s.eaddr = 32'h20; s.ewd = 32'h1234_5678; drive(s);
      s.ewe = 0; s.ef3 = F3_LW; s.ewd = '0; drive(s);
      s = '0; drive(s);
      // Locked EXT burst with the core waiting.
      s = '0; s.creq = 1; s.caddr = 32'h80; s.cf3 = F3_LW;
      s.ereq = 1; s.elock = 1; s.ef3 = F3_LW;
      for (int i = 0; i < 12; i++) begin s.eaddr = 32'(i * 4); drive(s); end
      s = '0; drive(s);
      // Burst interrupted by reset while an EXT load is granted.
      s = '0; s.creq = 1; s.caddr = 32'h84; s.cf3 = F3_LW;
      s.ereq = 1; s.elock = 1; s.eaddr = 32'h30; s.ef3 = F3_LW;
      repeat (4) drive(s);
      s.creq = 0; s.rst = 1; drive(s);
      s.creq = 1; s.rst = 0; drive(s);
      drive(s);

      // Randomized traffic; the core holds its request while stalled.
      s = '0;
      for (int n = 0; n < 800; n++) begin
         if (!prev_stall) begin
            s.creq  = ($urandom_range(0, 9) < 6);
            s.cwe   = $urandom_range(0, 1);
            s.cf3   = rand_f3(s.cwe);
            s.caddr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            s.cwd   = $urandom;
         end
         s.ereq  = ($urandom_range(0, 9) < 6);
         s.ewe   = ($urandom_range(0, 3) == 0);
         s.ef3   = rand_f3(s.ewe);
         s.eaddr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         s.ewd   = $urandom;
         s.elock = ($urandom_range(0, 9) < 7);
         s.rst   = ($urandom_range(0, 99) == 0);
         drive(s);
      end
      s = '0; drive(s); drive(s);

      repeat (3) @(negedge clk);
      #3;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
